// File: rtl/wb_regfile.sv
// wb_regfile: write-back register file with load extension, bypassed reads and a RAW busy scoreboard.
// Define WB_TRACE_EN to implement commit_valid/commit_rd/commit_data/retire_count; otherwise they tie to 0.
module wb_regfile #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            wb_valid,
    input  logic [4:0]      wb_rd,
    input  logic [1:0]      wb_sel,
    input  logic [2:0]      wb_funct3,
    input  logic [1:0]      wb_byte_off,
    input  logic [XLEN-1:0] wb_alu,
    input  logic [XLEN-1:0] wb_load,
    input  logic [XLEN-1:0] wb_pc4,
    input  logic            issue_valid,
    input  logic [4:0]      issue_rd,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    output logic            busy1,
    output logic            busy2,
    output logic            commit_valid,
    output logic [4:0]      commit_rd,
    output logic [XLEN-1:0] commit_data,
    output logic [31:0]     retire_count
);
    logic [XLEN-1:0] r_regs [NREGS];
    logic [NREGS-1:0] r_busy;
    logic [NREGS-1:0] w_busy_nxt;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic [XLEN-1:0] w_load_ext;
    logic [XLEN-1:0] w_wdata;
    logic            w_we;

    assign w_we   = wb_valid && (wb_rd != 5'd0);
    assign w_byte = wb_load[{wb_byte_off, 3'b000} +: 8];
    assign w_half = wb_load[{wb_byte_off[1], 4'b0000} +: 16];

    always_comb begin
        w_load_ext = wb_load;
        case (wb_funct3)
            3'b000:  w_load_ext = {{(XLEN-8){w_byte[7]}}, w_byte};
            3'b001:  w_load_ext = {{(XLEN-16){w_half[15]}}, w_half};
            3'b100:  w_load_ext = {{(XLEN-8){1'b0}}, w_byte};
            3'b101:  w_load_ext = {{(XLEN-16){1'b0}}, w_half};
            default: w_load_ext = wb_load;
        endcase
    end

    assign w_wdata = (wb_sel == 2'b00) ? wb_alu :
                     (wb_sel == 2'b01) ? w_load_ext :
                     (wb_sel == 2'b10) ? wb_pc4 : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
        end else if (w_we) begin
            r_regs[wb_rd] <= w_wdata;
        end
    end

    // Issue is applied after the clear so a newer producer stays pending.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_we) w_busy_nxt[wb_rd] = 1'b0;
        if (issue_valid && (issue_rd != 5'd0)) w_busy_nxt[issue_rd] = 1'b1;
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_busy <= '0;
        else          r_busy <= w_busy_nxt;
    end

    // Bypass is gated by reset so reads stay 0 while reset is held.
    assign rd1 = (!reset_n || rs1 == 5'd0) ? '0 : (w_we && wb_rd == rs1) ? w_wdata : r_regs[rs1];
    assign rd2 = (!reset_n || rs2 == 5'd0) ? '0 : (w_we && wb_rd == rs2) ? w_wdata : r_regs[rs2];
    assign busy1 = r_busy[rs1] && !(wb_valid && wb_rd == rs1);
    assign busy2 = r_busy[rs2] && !(wb_valid && wb_rd == rs2);

`ifdef WB_TRACE_EN
    logic            r_commit_valid;
    logic [4:0]      r_commit_rd;
    logic [XLEN-1:0] r_commit_data;
    logic [31:0]     r_retire_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_commit_valid <= 1'b0;
            r_commit_rd    <= '0;
            r_commit_data  <= '0;
            r_retire_count <= '0;
        end else begin
            r_commit_valid <= w_we;
            if (w_we) begin
                r_commit_rd    <= wb_rd;
                r_commit_data  <= w_wdata;
                r_retire_count <= r_retire_count + 32'd1;
            end
        end
    end

    assign commit_valid = r_commit_valid;
    assign commit_rd    = r_commit_rd;
    assign commit_data  = r_commit_data;
    assign retire_count = r_retire_count;
`else
    assign commit_valid = 1'b0;
    assign commit_rd    = '0;
    assign commit_data  = '0;
    assign retire_count = '0;
`endif
endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed stimulus with a queued scoreboard checked by a separate negedge monitor.
module tb_wb_regfile;
`ifdef WB_TRACE_EN
    localparam bit TRACE = 1'b1;
`else
    localparam bit TRACE = 1'b0;
`endif
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        wb_valid, issue_valid;
    logic [4:0]  wb_rd, issue_rd, rs1, rs2;
    logic [1:0]  wb_sel, wb_byte_off;
    logic [2:0]  wb_funct3;
    logic [31:0] wb_alu, wb_load, wb_pc4;
    logic [31:0] rd1, rd2, commit_data, retire_count;
    logic        busy1, busy2, commit_valid;
    logic [4:0]  commit_rd;

    wb_regfile dut (
        .clk(clk), .reset_n(reset_n), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_sel(wb_sel),
        .wb_funct3(wb_funct3), .wb_byte_off(wb_byte_off), .wb_alu(wb_alu), .wb_load(wb_load),
        .wb_pc4(wb_pc4), .issue_valid(issue_valid), .issue_rd(issue_rd), .rs1(rs1), .rs2(rs2),
        .rd1(rd1), .rd2(rd2), .busy1(busy1), .busy2(busy2), .commit_valid(commit_valid),
        .commit_rd(commit_rd), .commit_data(commit_data), .retire_count(retire_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int n_chk = 0;
    int n_err = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          q_cyc [$];
    int          q_sig [$];
    logic [31:0] q_exp [$];
    string       q_name [$];
    logic [4:0]  cq_rd [$];
    logic [31:0] cq_data [$];

    localparam int S_RD1 = 0, S_RD2 = 1, S_B1 = 2, S_B2 = 3, S_CV = 4, S_CRD = 5, S_CD = 6, S_RC = 7;

    function automatic logic [31:0] sample(input int s);
        case (s)
            S_RD1:   return rd1;
            S_RD2:   return rd2;
            S_B1:    return {31'b0, busy1};
            S_B2:    return {31'b0, busy2};
            S_CV:    return {31'b0, commit_valid};
            S_CRD:   return {27'b0, commit_rd};
            S_CD:    return commit_data;
            S_RC:    return retire_count;
            default: return 32'hx;
        endcase
    endfunction

    task automatic push(input int s, input logic [31:0] e, input string nm);
        q_cyc.push_back(cyc);
        q_sig.push_back(s);
        q_exp.push_back(e);
        q_name.push_back(nm);
    endtask

    task automatic push_commit(input logic [4:0] rd, input logic [31:0] d);
        if (TRACE && rd != 5'd0) begin
            cq_rd.push_back(rd);
            cq_data.push_back(d);
        end
    endtask

    always @(negedge clk) begin
        logic [31:0] a;
        logic [31:0] e;
        logic [4:0]  er;
        while (q_cyc.size() > 0 && q_cyc[0] <= cyc) begin
            a = sample(q_sig[0]);
            e = q_exp[0];
            n_chk++;
            if (a !== e) begin
                n_err++;
                $display("FAIL %s cyc=%0d got=%h expected=%h", q_name[0], cyc, a, e);
            end
            void'(q_cyc.pop_front());
            void'(q_sig.pop_front());
            void'(q_exp.pop_front());
            void'(q_name.pop_front());
        end
        if (commit_valid === 1'b1) begin
            n_chk++;
            if (cq_rd.size() == 0) begin
                n_err++;
                $display("FAIL commit_unexpected cyc=%0d got rd=%0d data=%h expected none", cyc, commit_rd, commit_data);
            end else begin
                er = cq_rd.pop_front();
                e = cq_data.pop_front();
                if (commit_rd !== er || commit_data !== e) begin
                    n_err++;
                    $display("FAIL commit cyc=%0d got rd=%0d data=%h expected rd=%0d data=%h",
                             cyc, commit_rd, commit_data, er, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wb_valid = 1'b0; wb_rd = '0; wb_sel = '0; wb_funct3 = '0; wb_byte_off = '0;
        wb_alu = '0; wb_load = '0; wb_pc4 = '0; issue_valid = 1'b0; issue_rd = '0;
        rs1 = '0; rs2 = '0;
    endtask

    logic [1:0]  v_sel [11];
    logic [2:0]  v_f3  [11];
    logic [1:0]  v_off [11];
    logic [31:0] v_exp [11];

    initial begin
        v_sel = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b11, 2'b00};
        v_f3  = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b000, 3'b001, 3'b011, 3'b000, 3'b000, 3'b000};
        v_off = '{2'd3, 2'd3, 2'd2, 2'd1, 2'd0, 2'd1, 2'd3, 2'd0, 2'd0, 2'd0, 2'd3};
        v_exp = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80F1, 32'h00007F01, 32'h80F17F01, 32'h0000007F,
                  32'hFFFF80F1, 32'h80F17F01, 32'h00000104, 32'h00000000, 32'h12345678};
        idle();
        reset_n = 1'b0;
        tick(); tick();
        reset_n = 1'b1;
        for (int r = 0; r < 32; r++) begin
            tick(); idle();
            rs1 = 5'(r); rs2 = 5'(31 - r);
            push(S_RD1, 32'h0, $sformatf("reset_rd1_x%0d", r));
            push(S_RD2, 32'h0, $sformatf("reset_rd2_x%0d", 31 - r));
            push(S_B1, 32'h0, "reset_busy1");
            push(S_B2, 32'h0, "reset_busy2");
            if (r == 0) begin
                push(S_RC, 32'h0, "reset_retire");
                push(S_CV, 32'h0, "reset_commit_valid");
                push(S_CD, 32'h0, "reset_commit_data");
            end
        end
        tick(); idle();
        wb_valid = 1'b1; wb_rd = 5'd5; wb_sel = 2'b00; wb_alu = 32'hDEADBEEF; rs1 = 5'd5;
        push(S_RD1, 32'hDEADBEEF, "alu_bypass");
        push_commit(5'd5, 32'hDEADBEEF);
        tick(); idle();
        rs1 = 5'd5;
        push(S_RD1, 32'hDEADBEEF, "alu_array");
        push(S_CV, TRACE ? 32'd1 : 32'd0, "alu_commit_valid");
        push(S_CRD, TRACE ? 32'd5 : 32'd0, "alu_commit_rd");
        push(S_RC, TRACE ? 32'd1 : 32'd0, "alu_retire");
        for (int k = 0; k < 11; k++) begin
            tick(); idle();
            wb_valid = 1'b1; wb_rd = 5'(10 + k); wb_sel = v_sel[k]; wb_funct3 = v_f3[k];
            wb_byte_off = v_off[k]; wb_load = 32'h80F17F01; wb_alu = 32'h12345678; wb_pc4 = 32'h104;
            rs1 = 5'(10 + k);
            push(S_RD1, v_exp[k], $sformatf("ext_bypass_%0d", k));
            if (k > 0) begin
                rs2 = 5'(9 + k);
                push(S_RD2, v_exp[k-1], $sformatf("ext_array_%0d", k - 1));
            end
            push_commit(5'(10 + k), v_exp[k]);
        end
        tick(); idle();
        wb_valid = 1'b1; wb_rd = 5'd0; wb_alu = 32'h1234; rs1 = 5'd0; rs2 = 5'd20;
        push(S_RD1, 32'h0, "x0_bypass");
        push(S_RD2, 32'h12345678, "ext_array_10");
        push(S_CV, TRACE ? 32'd1 : 32'd0, "ext_commit_valid");
        push(S_CRD, TRACE ? 32'd20 : 32'd0, "ext_commit_rd");
        push(S_CD, TRACE ? 32'h12345678 : 32'd0, "ext_commit_data");
        push(S_RC, TRACE ? 32'd12 : 32'd0, "ext_retire");
        tick(); idle();
        rs1 = 5'd0;
        push(S_RD1, 32'h0, "x0_array");
        push(S_CV, 32'h0, "x0_commit_valid");
        push(S_RC, TRACE ? 32'd12 : 32'd0, "x0_retire");
        tick(); idle();
        issue_valid = 1'b1; issue_rd = 5'd7; rs1 = 5'd7;
        push(S_B1, 32'h0, "issue_same_cycle");
        tick(); idle();
        rs1 = 5'd7; rs2 = 5'd8;
        push(S_B1, 32'h1, "issue_busy");
        push(S_B2, 32'h0, "other_not_busy");
        tick(); idle();
        wb_valid = 1'b1; wb_rd = 5'd7; wb_alu = 32'h77; issue_valid = 1'b1; issue_rd = 5'd7;
        rs1 = 5'd7; rs2 = 5'd7;
        push(S_B1, 32'h0, "setclr_busy1_now");
        push(S_B2, 32'h0, "setclr_busy2_now");
        push(S_RD1, 32'h77, "setclr_bypass");
        push_commit(5'd7, 32'h77);
        tick(); idle();
        rs1 = 5'd7;
        push(S_B1, 32'h1, "setclr_busy_next");
        push(S_RD1, 32'h77, "setclr_array");
        tick(); idle();
        wb_valid = 1'b1; wb_rd = 5'd7; wb_alu = 32'h78; rs1 = 5'd7;
        push(S_B1, 32'h0, "clr_busy_now");
        push(S_RD1, 32'h78, "clr_bypass");
        push_commit(5'd7, 32'h78);
        tick(); idle();
        rs1 = 5'd7; rs2 = 5'd7;
        push(S_B1, 32'h0, "clr_busy_after");
        push(S_RD2, 32'h78, "clr_array");
        push(S_RC, TRACE ? 32'd14 : 32'd0, "sb_retire");
        tick(); idle();
        wb_valid = 1'b1; wb_rd = 5'd3; wb_alu = 32'h55; issue_valid = 1'b1; issue_rd = 5'd3;
        push_commit(5'd3, 32'h55);
        tick(); idle();
        rs1 = 5'd3; rs2 = 5'd3;
        push(S_RD1, 32'h55, "pre_reset_x3");
        push(S_B1, 32'h1, "pre_reset_busy3");
        tick(); idle();
        reset_n = 1'b0;
        wb_valid = 1'b1; wb_rd = 5'd9; wb_alu = 32'h99; rs1 = 5'd3; rs2 = 5'd9;
        push(S_RD1, 32'h0, "async_reset_x3");
        push(S_B1, 32'h0, "async_reset_busy3");
        push(S_RD2, 32'h0, "reset_bypass_gated");
        push(S_RC, 32'h0, "async_reset_retire");
        push(S_CV, 32'h0, "async_reset_commit_valid");
        tick(); tick(); idle();
        reset_n = 1'b1;
        tick(); idle();
        rs1 = 5'd9; rs2 = 5'd3;
        push(S_RD1, 32'h0, "reset_write_dropped");
        push(S_RD2, 32'h0, "post_reset_x3");
        push(S_B2, 32'h0, "post_reset_busy3");
        tick(); idle();
        wb_valid = 1'b1; wb_rd = 5'd9; wb_alu = 32'hA5; rs1 = 5'd9;
        push(S_RD1, 32'hA5, "post_reset_bypass");
        push_commit(5'd9, 32'hA5);
        tick(); idle();
        rs1 = 5'd9;
        push(S_RD1, 32'hA5, "post_reset_array");
        push(S_RC, TRACE ? 32'd1 : 32'd0, "post_reset_retire");
        tick(); idle();
        repeat (3) @(negedge clk);
        n_chk++;
        if (q_cyc.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain got=%0d pending expected=0", q_cyc.size());
        end
        n_chk++;
        if (cq_rd.size() != 0) begin
            n_err++;
            $display("FAIL commit_drain got=%0d pending expected=0", cq_rd.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
